// File: rtl/stand_src_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stand_src_pkg
// Brief    : Shared FSM encoding, LFSR constants and helpers for stand_src.
// Revision : 1.0 - initial release
// ============================================================================
package stand_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DLY = 2'd1,
    ST_SEND     = 2'd2,
    ST_FINISH   = 2'd3
  } state_t;

  localparam logic [31:0] C_LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] C_ZERO_SEED_SUB = 32'h0000_0001;

  // An all-zero Galois LFSR never leaves zero, so a zero seed is substituted.
  function automatic logic [31:0] fix_seed(input logic [31:0] seed);
    return (seed == 32'h0) ? C_ZERO_SEED_SUB : seed;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ C_LFSR_POLY) : (v >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stand_lfsr32.sv
`default_nettype none
// ============================================================================
// Module   : stand_lfsr32
// Brief    : 32-bit right-shifting Galois LFSR, one step per asserted step.
// Revision : 1.0 - initial release
// ============================================================================
module stand_lfsr32 (
  input  logic        clk,
  input  logic        rst_,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);
  import stand_src_pkg::*;

  logic [31:0] r_value;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_value <= fix_seed(seed);
    end else if (step) begin
      r_value <= lfsr_step(r_value);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/stand_src.sv
`default_nettype none
// ============================================================================
// Module   : stand_src
// Brief    : Paced pseudo-random transaction source with tag, count and XOR sum.
// Revision : 1.0 - initial release
// ============================================================================
module stand_src #(
  parameter int          DATA_W   = 32,
  parameter int          ID_W     = 4,
  parameter int          NUM_TX   = 64,
  parameter logic [31:0] SRC_SEED = 32'h1d76993a
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              run,
  output logic              delay_start,
  input  logic              delay_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic [15:0]       tx_cnt,
  output logic [DATA_W-1:0] csum,
  output logic              all_done
);
  import stand_src_pkg::*;

  localparam logic [15:0] C_LAST_IDX = 16'(NUM_TX - 1);

  state_t            r_state;
  logic              r_out_valid;
  logic              r_all_done;
  logic [ID_W-1:0]   r_out_id;
  logic [15:0]       r_tx_cnt;
  logic [DATA_W-1:0] r_csum;
  logic [31:0]       w_lfsr;
  logic              w_hs;
  logic              w_unused_lfsr;

  assign w_hs = r_out_valid && out_ready;

  stand_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_  (rst_),
    .seed  (SRC_SEED),
    .step  (w_hs),
    .value (w_lfsr)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_all_done  <= 1'b0;
      r_out_id    <= '0;
      r_tx_cnt    <= '0;
      r_csum      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state  <= ST_WAIT_DLY;
            r_out_id <= '0;
            r_tx_cnt <= '0;
            r_csum   <= '0;
          end
        end
        ST_WAIT_DLY: begin
          if (delay_done) begin
            r_state     <= ST_SEND;
            r_out_valid <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_tx_cnt    <= r_tx_cnt + 16'd1;
            r_csum      <= r_csum ^ w_lfsr[DATA_W-1:0];
            r_out_id    <= r_out_id + ID_W'(1);
            if (r_tx_cnt == C_LAST_IDX) begin
              r_state    <= ST_FINISH;
              r_all_done <= 1'b1;
            end else begin
              r_state <= ST_WAIT_DLY;
            end
          end
        end
        ST_FINISH: begin
          r_all_done <= 1'b0;
          if (run) begin
            r_state  <= ST_WAIT_DLY;
            r_out_id <= '0;
            r_tx_cnt <= '0;
            r_csum   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The companion delay generator sees its own expiry echoed only while waiting.
  assign delay_start = (r_state == ST_WAIT_DLY) && delay_done;

  assign out_valid     = r_out_valid;
  assign out_data      = w_lfsr[DATA_W-1:0];
  assign out_id        = r_out_id;
  assign tx_cnt        = r_tx_cnt;
  assign csum          = r_csum;
  assign all_done      = r_all_done;
  assign w_unused_lfsr = ^w_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_stand_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_stand_src
// Brief    : Directed self-checking bench for stand_src (two parameterisations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stand_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_;

  // Instance A: default widths, four transactions per run
  logic        a_run, a_dd, a_rdy, a_ds, a_ov, a_done;
  logic [31:0] a_data, a_csum;
  logic [3:0]  a_id;
  logic [15:0] a_cnt;

  // Instance B: 16-bit payload, 2-bit tags, six transactions, zero seed
  logic        b_run, b_dd, b_rdy, b_ds, b_ov, b_done;
  logic [15:0] b_data, b_csum;
  logic [1:0]  b_id;
  logic [15:0] b_cnt;

  stand_src #(.DATA_W(32), .ID_W(4), .NUM_TX(4), .SRC_SEED(32'h1d76993a)) u_dut_a (
    .clk(clk), .rst_(rst_), .run(a_run), .delay_start(a_ds), .delay_done(a_dd),
    .out_valid(a_ov), .out_ready(a_rdy), .out_data(a_data), .out_id(a_id),
    .tx_cnt(a_cnt), .csum(a_csum), .all_done(a_done)
  );

  stand_src #(.DATA_W(16), .ID_W(2), .NUM_TX(6), .SRC_SEED(32'h0)) u_dut_b (
    .clk(clk), .rst_(rst_), .run(b_run), .delay_start(b_ds), .delay_done(b_dd),
    .out_valid(b_ov), .out_ready(b_rdy), .out_data(b_data), .out_id(b_id),
    .tx_cnt(b_cnt), .csum(b_csum), .all_done(b_done)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] c_exp_a1 [4] = '{32'h1d76993a, 32'h0ebb4c9d, 32'h877da64d, 32'hc39ed325};
  logic [15:0] c_exp_b  [6] = '{16'h0001, 16'h0003, 16'h0002, 16'h0001, 16'h0003, 16'h0002};
  int          c_exp_bid[6] = '{0, 1, 2, 3, 0, 1};

  logic [31:0] a_lfsr;
  logic [31:0] q_data[$];
  int          q_id[$];
  int          q_cyc[$];

  task automatic a_collect();
    logic done = 1'b0;
    q_data.delete(); q_id.delete(); q_cyc.delete();
    for (int c = 0; c < 300 && !done; c++) begin
      if (a_ov && a_rdy) begin
        q_data.push_back(a_data); q_id.push_back(int'(a_id)); q_cyc.push_back(c);
      end
      if (a_done) done = 1'b1;
      tick();
    end
    check("a_all_done_seen", done, 1);
  endtask

  task automatic b_collect();
    logic done = 1'b0;
    q_data.delete(); q_id.delete(); q_cyc.delete();
    for (int c = 0; c < 300 && !done; c++) begin
      if (b_ov && b_rdy) begin
        q_data.push_back({16'h0, b_data}); q_id.push_back(int'(b_id)); q_cyc.push_back(c);
      end
      if (b_done) done = 1'b1;
      tick();
    end
    check("b_all_done_seen", done, 1);
  endtask

  // Checks one finished run of A against the bench LFSR model, advancing it.
  task automatic a_check_run(input string tag);
    logic [31:0] cs = '0;
    check({tag, "_n"}, q_data.size(), 4);
    foreach (q_data[i]) begin
      check({tag, "_data"}, q_data[i], a_lfsr);
      check({tag, "_id"}, q_id[i], i % 16);
      cs     ^= a_lfsr;
      a_lfsr  = lstep(a_lfsr);
    end
    check({tag, "_cnt"}, a_cnt, 4);
    check({tag, "_csum"}, a_csum, cs);
  endtask

  task automatic a_pulse_run();
    a_run = 1'b1; tick(); a_run = 1'b0;
  endtask

  initial begin
    logic [15:0] bcs;
    logic [31:0] bm;
    int          hs;

    rst_ = 1'b0;
    a_run = 1'b0; a_dd = 1'b1; a_rdy = 1'b1;
    b_run = 1'b0; b_dd = 1'b1; b_rdy = 1'b1;
    a_lfsr = 32'h1d76993a;
    repeat (3) tick();

    // Reset state
    check("rst_valid", a_ov, 0);
    check("rst_dstart", a_ds, 0);
    check("rst_done", a_done, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_csum", a_csum, 0);
    check("rst_id", a_id, 0);
    check("rst_data", a_data, 32'h1d76993a);
    check("rst_b_data_seed0", b_data, 16'h0001);
    rst_ = 1'b1;
    tick();
    check("idle_dstart", a_ds, 0);

    // Back-to-back run with delay and ready tied high
    a_pulse_run();
    a_collect();
    foreach (q_data[i]) begin
      if (i < 4) check("r1_const_data", q_data[i], c_exp_a1[i]);
      if (i > 0) check("r1_gap", q_cyc[i] - q_cyc[i-1], 2);
    end
    check("r1_csum_const", a_csum, 32'h572ea0cf);
    a_check_run("r1");

    // Narrow-tag instance: tag wrap and zero-seed substitution
    b_run = 1'b1; tick(); b_run = 1'b0;
    b_collect();
    check("b_n", q_data.size(), 6);
    bcs = '0;
    bm  = 32'h1;
    foreach (q_data[i]) begin
      if (i < 6) begin
        check("b_data", q_data[i], {16'h0, c_exp_b[i]});
        check("b_id", q_id[i], c_exp_bid[i]);
      end
      check("b_model_data", q_data[i], {16'h0, bm[15:0]});
      bcs ^= bm[15:0];
      bm   = lstep(bm);
    end
    check("b_cnt", b_cnt, 6);
    check("b_csum_model", b_csum, bcs);
    check("b_csum_const", b_csum, 16'h0000);

    // Stall in SEND with delay_done also dropping
    a_rdy = 1'b0;
    a_pulse_run();
    for (int c = 0; c < 10 && !a_ov; c++) tick();
    check("st_enter_valid", a_ov, 1);
    a_dd = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("st_valid", a_ov, 1);
      check("st_data", a_data, a_lfsr);
      check("st_id", a_id, 0);
      check("st_cnt", a_cnt, 0);
      tick();
    end
    a_dd  = 1'b1;
    a_rdy = 1'b1;
    a_collect();
    a_check_run("st");

    // Delay generator slow to expire
    a_dd = 1'b0;
    a_pulse_run();
    for (int c = 0; c < 7; c++) begin
      check("dl_dstart_low", a_ds, 0);
      check("dl_valid_low", a_ov, 0);
      tick();
    end
    a_dd = 1'b1;
    #1;
    check("dl_dstart_rise", a_ds, 1);
    tick();
    check("dl_dstart_one_cycle", a_ds, 0);
    check("dl_valid_up", a_ov, 1);
    a_collect();
    a_check_run("dl");

    // Reset during the third SEND of a run
    a_pulse_run();
    hs = 0;
    for (int c = 0; c < 40 && hs < 2; c++) begin
      if (a_ov && a_rdy) hs++;
      tick();
    end
    for (int c = 0; c < 5 && !a_ov; c++) tick();
    check("rs_pre_valid", a_ov, 1);
    check("rs_pre_cnt", a_cnt, 2);
    rst_ = 1'b0;
    #1;
    check("rs_valid_drop", a_ov, 0);
    check("rs_cnt", a_cnt, 0);
    check("rs_csum", a_csum, 0);
    tick();
    rst_ = 1'b1;
    tick();
    a_pulse_run();
    for (int c = 0; c < 10 && !a_ov; c++) tick();
    check("rs_post_valid", a_ov, 1);
    check("rs_first_data", a_data, 32'h1d76993a);
    check("rs_first_id", a_id, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stand_src.md
STAND_SRC -- requirements
Module: stand_src

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width, 8..32.
REQ-002 SHALL have parameter ID_W, default 4: transaction tag width; tags wrap modulo 2^ID_W.
REQ-003 SHALL have parameter NUM_TX, default 64: transactions per run, 1..65535.
REQ-004 SHALL have parameter SRC_SEED, default 32'h1d76993a: LFSR seed; value 0 replaced by 32'h1.
REQ-005 SHALL have port clk  input  1: single clock, all state on posedge.
REQ-006 SHALL have port rst_  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port run  input  1: level-sampled start request.
REQ-008 SHALL have port delay_start  output  1: request to the companion delay generator.
REQ-009 SHALL have port delay_done  input  1: delay generator has expired.
REQ-010 SHALL have port out_valid  output  1: transaction present.
REQ-011 SHALL have port out_ready  input  1: downstream accepts.
REQ-012 SHALL have port out_data  output  DATA_W: payload.
REQ-013 SHALL have port out_id  output  ID_W: tag.
REQ-014 SHALL have port tx_cnt  output  16: accepted transactions this run.
REQ-015 SHALL have port csum  output  DATA_W: XOR of all accepted payloads this run.
REQ-016 SHALL have port all_done  output  1: run complete.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_DLY, SEND, FINISH.
REQ-018 IDLE: outputs quiet; run=1 -> WAIT_DLY next cycle, tx_cnt, csum, out_id cleared at that edge.
REQ-019 WAIT_DLY: delay_start = delay_done (combinational, this state only); delay_done=1 -> SEND next cycle.
REQ-020 SEND: out_valid=1; out_data, out_id held stable until handshake (out_valid & out_ready).
REQ-021 On handshake: tx_cnt+1, csum ^= out_data, out_id+1 (wraps), LFSR advances one step.
REQ-022 On handshake with tx_cnt==NUM_TX-1 -> FINISH; otherwise -> WAIT_DLY.
REQ-023 Back-to-back: if delay_done already 1 in WAIT_DLY, spacing between handshakes SHALL be exactly 2 cycles with out_ready held 1.
REQ-024 FINISH: all_done=1, out_valid=0, delay_start=0; run=1 -> WAIT_DLY with counters cleared (same as REQ-018); run=0 -> IDLE.
REQ-025 out_data = LFSR[DATA_W-1:0]; LFSR 32-bit Galois, polynomial 32'h80200003, shift right, XOR taps when bit0=1.
REQ-026 out_ready while out_valid=0 SHALL be ignored; run changes outside IDLE/FINISH ignored.
REQ-027 delay_done dropping in SEND SHALL have no effect.
REQ-028 tx_cnt saturates never beyond NUM_TX; csum width exactly DATA_W, no carries.

Reset
REQ-029 rst_=0 SHALL asynchronously force: state IDLE, out_valid 0, delay_start 0, all_done 0, tx_cnt 0, csum 0, out_id 0, LFSR = seed (SRC_SEED, or 1 if 0).
REQ-030 Reset mid-SEND SHALL drop out_valid immediately, no handshake counted; after release LFSR sequence restarts from seed.

Structure
REQ-031 Shared bench package SHALL hold the FSM state encoding, LFSR polynomial constant and zero-seed substitute.
REQ-032 LFSR SHALL be sub-module stand_lfsr32 (ports clk, rst_, seed, step, value).
REQ-033 stand_src SHALL NOT contain delay logic; delay_start/delay_done connect to a separately instantiated delay generator.

Verification
REQ-034 NUM_TX=4, delay_done tied 1, out_ready tied 1, run pulse -> 4 handshakes 2 cycles apart, out_id 0,1,2,3, all_done=1, tx_cnt=4.
REQ-035 out_ready held 0 for 10 cycles in SEND -> out_valid, out_data, out_id constant all 10 cycles; tx_cnt unchanged.
REQ-036 ID_W=2, NUM_TX=6 -> out_id sequence 0,1,2,3,0,1.
REQ-037 rst_ low during 3rd SEND -> out_valid 0 same cycle; after release and run, first out_data equals first payload of prior run.
REQ-038 SRC_SEED=0 -> first out_data equals value with seed 1; csum equals XOR of model LFSR outputs.
REQ-039 delay_done low 7 cycles in WAIT_DLY -> delay_start stays 0, out_valid 0; delay_start 1 for exactly one cycle when delay_done rises.
